// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO scheduler:
// FSM state codes, default geometry and threshold width.
package fifo_rr_scheduler_pkg;

  localparam int N_SRC_DEF    = 4;
  localparam int IDX_W_DEF    = 2;
  localparam int BUS_SIZE_DEF = 5;
  localparam int UMB_W        = 4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter. Searches req from ptr+1
// (mod N) upward; ports: req, ptr, en -> gnt_onehot, gnt_idx, any.
module fifo_rr_scheduler_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic          found;
  logic [IW-1:0] idx;

  assign any = |req;

  // N is a power of two, so IW-bit addition wraps modulo N.
  always_comb begin
    found      = 1'b0;
    idx        = '0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && found) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains N_SRC source FIFOs round-robin into one destination FIFO.
// Ports: config (init, umbral_*), per-source flags/data, dst flow ctl.
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int N_SRC    = N_SRC_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int BUS_SIZE = BUS_SIZE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [UMB_W-1:0]          umbral_a_in,
  input  logic [UMB_W-1:0]          umbral_b_in,
  input  logic [N_SRC-1:0]          src_empty,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*BUS_SIZE-1:0] src_data,
  input  logic [N_SRC-1:0]          src_error,
  input  logic                      dst_pause,
  input  logic                      dst_continua,
  input  logic                      dst_error,
  output logic [N_SRC-1:0]          src_pop,
  output logic                      dst_push,
  output logic [BUS_SIZE-1:0]       dst_data,
  output logic                      dst_valid,
  output logic [UMB_W-1:0]          umbralA,
  output logic [UMB_W-1:0]          umbralB,
  output logic [1:0]                state,
  output logic                      idle,
  output logic                      error_out
);

  state_e             state_q, state_d;
  logic [UMB_W-1:0]   umb_a_q, umb_a_d;
  logic [UMB_W-1:0]   umb_b_q, umb_b_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               stall_q, stall_d;
  logic               push_q, push_d;

  logic               any_req;
  logic               any_err;
  logic               issue;
  logic [IDX_W-1:0]   gnt_idx;
  logic [BUS_SIZE-1:0] sel_data;

  assign any_err = (|src_error) | dst_error;
  assign issue   = (state_q == ST_ACTIVE) && !stall_q
                && !dst_pause && any_req;

  fifo_rr_scheduler_rr_arbiter #(
    .N  (N_SRC),
    .IW (IDX_W)
  ) u_arb (
    .req        (~src_empty),
    .ptr        (rr_ptr_q),
    .en         (issue),
    .gnt_onehot (src_pop),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  always_comb begin
    state_d = state_q;
    umb_a_d = umb_a_q;
    umb_b_d = umb_b_q;
    if (state_q == ST_INIT) begin
      umb_a_d = umbral_a_in;
      umb_b_d = umbral_b_in;
    end
    unique case (state_q)
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init) state_d = ST_INIT;
        else if (any_req) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Stay until the last popped word has been pushed.
        if (init) state_d = ST_INIT;
        else if (!any_req && !push_q) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
    endcase
    if (any_err && state_q != ST_ERROR) state_d = ST_ERROR;
  end

  always_comb begin
    stall_d = stall_q;
    if (dst_pause) stall_d = 1'b1;
    else if (dst_continua) stall_d = 1'b0;
    push_d   = issue;
    rr_ptr_d = issue ? gnt_idx : rr_ptr_q;
    gnt_d    = issue ? gnt_idx : gnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      umb_a_q  <= '0;
      umb_b_q  <= '0;
      rr_ptr_q <= IDX_W'(N_SRC - 1);
      gnt_q    <= '0;
      stall_q  <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      umb_a_q  <= umb_a_d;
      umb_b_q  <= umb_b_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      stall_q  <= stall_d;
      push_q   <= push_d;
    end
  end

  // Source data_out is registered, so the popped word shows up
  // on the granted source one cycle after its pop.
  assign sel_data  = src_data[int'(gnt_q)*BUS_SIZE +: BUS_SIZE];
  assign dst_push  = push_q;
  assign dst_data  = push_q ? sel_data : '0;
  assign dst_valid = push_q & src_valid[gnt_q];
  assign umbralA   = umb_a_q;
  assign umbralB   = umb_b_q;
  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);

endmodule
